// File: rtl/sram_pkg.sv
// Shared types and helpers for the sram_1rw1r family: clear-sweep state encoding,
// byte-lane merge and the lane-geometry check used at elaboration.
package sram_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } clear_state_t;

  localparam int unsigned MAX_DATA_WIDTH = 1024;
  localparam int unsigned MAX_WMASKS     = 128;
  localparam int unsigned DATA_IDX_W     = $clog2(MAX_DATA_WIDTH);
  localparam int unsigned MASK_IDX_W     = $clog2(MAX_WMASKS);

  typedef logic [MAX_DATA_WIDTH-1:0] wide_word_t;
  typedef logic [MAX_WMASKS-1:0]     wide_mask_t;

  function automatic bit lanes_ok(input int unsigned data_width, input int unsigned num_wmasks);
    return (num_wmasks != 0) && (data_width % num_wmasks == 0) &&
           (data_width <= MAX_DATA_WIDTH) && (num_wmasks <= MAX_WMASKS);
  endfunction

  // Lanes with a set mask bit take new_word, all other bits keep old_word.
  function automatic wide_word_t merge(input wide_word_t  old_word,
                                       input wide_word_t  new_word,
                                       input wide_mask_t  mask,
                                       input int unsigned num_wmasks,
                                       input int unsigned data_width);
    wide_word_t  result;
    int unsigned lane_width;
    result     = old_word;
    lane_width = data_width / num_wmasks;
    for (int unsigned b = 0; b < data_width; b++) begin
      if (mask[MASK_IDX_W'(b / lane_width)]) result[DATA_IDX_W'(b)] = new_word[DATA_IDX_W'(b)];
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// Post-reset clear sweep for sram_1rw1r: zeroes every word, one per cycle, while busy is high.
// Only compiled into the design when SRAM_CLEAR_EN is defined.
`ifdef SRAM_CLEAR_EN
module sram_clear_fsm
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int unsigned IDX_W      = ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic             busy,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_idx
);

  clear_state_t          state;
  logic [ADDR_WIDTH:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (state == CLEAR) begin
      cnt <= cnt + (ADDR_WIDTH + 1)'(1);
      if (cnt == (ADDR_WIDTH + 1)'(RAM_DEPTH - 1)) begin
        state <= READY;
        busy  <= 1'b0;
      end
    end
  end

  assign clr_we  = (state == CLEAR) && !rst;
  assign clr_idx = cnt[IDX_W-1:0];

endmodule
`endif

// File: rtl/sram_1rw1r.sv
// 1RW + 1R synchronous SRAM model with byte-lane masks, write-first bypass to port 1,
// read-valid strobes and out-of-range flagging. Define SRAM_CLEAR_EN for the post-reset clear sweep.
module sram_1rw1r
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int unsigned NUM_WMASKS = DATA_WIDTH / 8
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  busy,
  output logic                  addr_err
);

  localparam int unsigned IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  if (!lanes_ok(DATA_WIDTH, NUM_WMASKS)) begin : g_bad_lanes
    $error("sram_1rw1r: DATA_WIDTH must be a multiple of NUM_WMASKS");
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  acc0, acc1, in0, in1, wr0, rd0, bypass;
  logic [IDX_W-1:0]      idx0, idx1, clr_idx;
  logic                  clr_we;
  logic [DATA_WIDTH-1:0] old0, wdata0;

`ifdef SRAM_CLEAR_EN
  sram_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_clear (
    .clk     (clk0),
    .rst     (rst0),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );
`else
  assign busy    = 1'b0;
  assign clr_we  = 1'b0;
  assign clr_idx = '0;
`endif

  always_comb begin
    acc0   = !csb0 && !busy && !rst0;
    acc1   = !csb1 && !busy && !rst0;
    in0    = {1'b0, addr0} < (ADDR_WIDTH + 1)'(RAM_DEPTH);
    in1    = {1'b0, addr1} < (ADDR_WIDTH + 1)'(RAM_DEPTH);
    idx0   = addr0[IDX_W-1:0];
    idx1   = addr1[IDX_W-1:0];
    wr0    = acc0 && !web0;
    rd0    = acc0 && web0;
    old0   = in0 ? mem[idx0] : '0;
    wdata0 = DATA_WIDTH'(merge(wide_word_t'(old0), wide_word_t'(din0), wide_mask_t'(wmask0),
                               NUM_WMASKS, DATA_WIDTH));
    // Port 1 sees the merged word when port 0 writes the same in-range address.
    bypass = wr0 && in0 && (addr0 == addr1);
  end

  always_ff @(posedge clk0) begin
    if (clr_we) mem[clr_idx] <= '0;
    else if (wr0 && in0) mem[idx0] <= wdata0;
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      dout0       <= '0;
      dout1       <= '0;
      dout0_valid <= 1'b0;
      dout1_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      dout0_valid <= rd0;
      dout1_valid <= acc1;
      addr_err    <= (acc0 && !in0) || (acc1 && !in1);
      if (rd0) dout0 <= in0 ? mem[idx0] : '0;
      if (acc1) begin
        if (!in1)       dout1 <= '0;
        else if (bypass) dout1 <= wdata0;
        else            dout1 <= mem[idx1];
      end
    end
  end

endmodule

// File: tb/tb_sram_1rw1r.sv
// Scoreboard bench for sram_1rw1r; the clear-sweep scenarios are included when SRAM_CLEAR_EN is defined.
module tb_sram_1rw1r;

`ifdef SRAM_CLEAR_EN
  localparam int unsigned DEPTH = 16;
  localparam logic        BUSY_AT_RESET = 1'b1;
`else
  localparam int unsigned DEPTH = 1000;
  localparam logic        BUSY_AT_RESET = 1'b0;
`endif
  localparam logic [9:0] ALIAS = 10'(1020 % DEPTH);

  logic        clk0 = 1'b0;
  logic        rst0, csb0, web0, csb1;
  logic [9:0]  addr0, addr1;
  logic [31:0] din0;
  logic [3:0]  wmask0;
  logic [31:0] dout0, dout1;
  logic        dout0_valid, dout1_valid, busy, addr_err;

  sram_1rw1r #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (10),
    .RAM_DEPTH  (DEPTH),
    .NUM_WMASKS (4)
  ) dut (
    .clk0        (clk0),
    .rst0        (rst0),
    .csb0        (csb0),
    .web0        (web0),
    .addr0       (addr0),
    .din0        (din0),
    .wmask0      (wmask0),
    .dout0       (dout0),
    .dout0_valid (dout0_valid),
    .csb1        (csb1),
    .addr1       (addr1),
    .dout1       (dout1),
    .dout1_valid (dout1_valid),
    .busy        (busy),
    .addr_err    (addr_err)
  );

  always #5 clk0 = ~clk0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  bit   err_at[int];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk0) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: expected strobes carry the cycle they must appear in.
  always @(negedge clk0) begin
    exp_t e;
    while (q0.size() > 0 && q0[0].cyc < cyc) begin
      e = q0.pop_front();
      checks++; failures++;
      $display("FAIL port0_missing_strobe: got none, expected %h at cycle %0d", e.data, e.cyc);
    end
    while (q1.size() > 0 && q1[0].cyc < cyc) begin
      e = q1.pop_front();
      checks++; failures++;
      $display("FAIL port1_missing_strobe: got none, expected %h at cycle %0d", e.data, e.cyc);
    end
    if (dout0_valid) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL port0_unexpected_strobe: got dout0=%h, expected no strobe (cycle %0d)", dout0, cyc);
      end else begin
        e = q0.pop_front();
        check("port0_data", dout0, e.data);
        check("port0_latency", 32'(cyc), 32'(e.cyc));
      end
    end
    if (dout1_valid) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL port1_unexpected_strobe: got dout1=%h, expected no strobe (cycle %0d)", dout1, cyc);
      end else begin
        e = q1.pop_front();
        check("port1_data", dout1, e.data);
        check("port1_latency", 32'(cyc), 32'(e.cyc));
      end
    end
    if (err_at.exists(cyc) || addr_err)
      check("addr_err", {31'b0, addr_err}, {31'b0, err_at.exists(cyc)});
  end

  // One request cycle: drive, record expectations for the following edge, advance.
  task automatic step(input bit en0, input bit we0, input logic [9:0] a0, input logic [31:0] d0,
                      input logic [3:0] m0, input bit en1, input logic [9:0] a1,
                      input logic [31:0] e0, input logic [31:0] e1, input bit err);
    csb0 = !en0; web0 = !we0; addr0 = a0; din0 = d0; wmask0 = m0;
    csb1 = !en1; addr1 = a1;
    if (en0 && !we0) q0.push_back('{e0, cyc + 1});
    if (en1) q1.push_back('{e1, cyc + 1});
    if (err) err_at[cyc + 1] = 1'b1;
    @(posedge clk0); #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m, input bit err);
    step(1'b1, 1'b1, a, d, m, 1'b0, 10'd0, 32'd0, 32'd0, err);
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] e, input bit err);
    step(1'b1, 1'b0, a, 32'd0, 4'h0, 1'b0, 10'd0, e, 32'd0, err);
  endtask

  task automatic idle(input int n);
    csb0 = 1'b1; csb1 = 1'b1; web0 = 1'b1;
    repeat (n) @(posedge clk0);
    #1;
  endtask

  task automatic sweep_count(output int n);
    n = 0;
    while (busy === 1'b1 && n < int'(DEPTH) + 8) begin
      @(posedge clk0); #1;
      n++;
    end
  endtask

  function automatic logic [31:0] pre(input int a);
    return 32'hC0DE_0000 + 32'(a) * 32'h0000_0111;
  endfunction

  initial begin
    int n;
    rst0 = 1'b1; csb0 = 1'b1; csb1 = 1'b1; web0 = 1'b1;
    addr0 = '0; addr1 = '0; din0 = '0; wmask0 = '0;
    repeat (3) @(posedge clk0);
    #1;
    check("reset_dout0", dout0, 32'd0);
    check("reset_dout1", dout1, 32'd0);
    check("reset_flags", {28'd0, dout0_valid, dout1_valid, addr_err, busy},
          {28'd0, 1'b0, 1'b0, 1'b0, BUSY_AT_RESET});
    rst0 = 1'b0;
`ifdef SRAM_CLEAR_EN
    sweep_count(n);
    check("init_sweep_cycles", 32'(n), 32'(DEPTH));
`endif

    for (int a = 0; a < 16; a++) wr(10'(a), pre(a), 4'hF, 1'b0);
    for (int i = 0; i < 64; i++)
      step(1'b1, 1'b0, 10'(i % 16), 32'd0, 4'h0, 1'b1, 10'((i + 8) % 16),
           pre(i % 16), pre((i + 8) % 16), 1'b0);
    idle(2);

    wr(10'd5, 32'hDEAD_BEEF, 4'hF, 1'b0);
    rd(10'd5, 32'hDEAD_BEEF, 1'b0);
    wr(10'd7, 32'h1122_3344, 4'hF, 1'b0);
    wr(10'd7, 32'hAABB_CCDD, 4'h5, 1'b0);
    rd(10'd7, 32'h11BB_33DD, 1'b0);
    wr(10'd7, 32'hFFFF_FFFF, 4'h0, 1'b0);
    rd(10'd7, 32'h11BB_33DD, 1'b0);
    wr(10'd9, 32'h1234_5678, 4'hF, 1'b0);
    step(1'b1, 1'b1, 10'd9, 32'hCAFE_F00D, 4'h3, 1'b1, 10'd9, 32'd0, 32'h1234_F00D, 1'b0);
    rd(10'd9, 32'h1234_F00D, 1'b0);

    wr(10'(DEPTH - 1), 32'h0BAD_F00D, 4'hF, 1'b0);
    step(1'b1, 1'b0, 10'(DEPTH - 1), 32'd0, 4'h0, 1'b1, 10'(DEPTH - 1),
         32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
    wr(ALIAS, 32'h5A5A_5A5A, 4'hF, 1'b0);
    wr(10'd1020, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd(10'd1020, 32'd0, 1'b1);
    rd(ALIAS, 32'h5A5A_5A5A, 1'b0);
    rd(10'(DEPTH), 32'd0, 1'b1);
    step(1'b1, 1'b0, 10'd1000, 32'd0, 4'h0, 1'b1, 10'd1023, 32'd0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 10'd5, 32'd0, 4'h0, 1'b1, 10'd1023, 32'hDEAD_BEEF, 32'd0, 1'b1);
    idle(3);
    check("dout0_hold", dout0, 32'hDEAD_BEEF);
    check("dout1_hold", dout1, 32'd0);

`ifdef SRAM_CLEAR_EN
    rst0 = 1'b1;
    repeat (2) @(posedge clk0);
    #1;
    rst0 = 1'b0;
    sweep_count(n);
    check("clear_sweep_cycles", 32'(n), 32'(DEPTH));
    for (int a = 0; a < 16; a++)
      step(1'b1, 1'b0, 10'(a), 32'd0, 4'h0, 1'b1, 10'(15 - a), 32'd0, 32'd0, 1'b0);
    idle(2);

    wr(10'd3, 32'h3333_3333, 4'hF, 1'b0);
    rst0 = 1'b1;
    @(posedge clk0); #1;
    rst0 = 1'b0;
    repeat (8) @(posedge clk0);
    #1;
    check("busy_mid_sweep", {31'b0, busy}, 32'd1);
    rst0 = 1'b1;
    @(posedge clk0); #1;
    rst0 = 1'b0;
    // Requests held for the whole sweep must be ignored.
    csb0 = 1'b0; web0 = 1'b0; addr0 = 10'd3; din0 = 32'hEEEE_EEEE; wmask0 = 4'hF;
    csb1 = 1'b0; addr1 = 10'd3;
    sweep_count(n);
    csb0 = 1'b1; csb1 = 1'b1; web0 = 1'b1;
    check("restart_sweep_cycles", 32'(n), 32'(DEPTH));
    rd(10'd3, 32'd0, 1'b0);
    rd(10'd0, 32'd0, 1'b0);
    idle(3);
`endif

    check("port0_pending", 32'(q0.size()), 32'd0);
    check("port1_pending", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
